// File: rtl/ddram_clear_pkg.sv
// Shared types and widths for the DDR3 fill engine.
package ddram_clear_pkg;

  localparam int DDR_AW = 29;          // 64-bit word address width
  localparam int DDR_DW = 64;          // data width
  localparam int BCNT_W = 8;           // burst count width
  localparam int WIN_W  = DDR_AW + 1;  // window arithmetic, one spare bit for the +1

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ddram_burst_len.sv
// Burst length for a burst starting at addr: min(BURST, ADDR_END - addr + 1).
module ddram_burst_len
  import ddram_clear_pkg::*;
#(
  parameter logic [DDR_AW-1:0] ADDR_END = 29'h1FFFFFF,
  parameter int                BURST    = 64
)(
  input  logic [DDR_AW-1:0] addr,
  output logic [BCNT_W-1:0] len
);

  localparam logic [WIN_W-1:0] BURST_W = WIN_W'(BURST);

  logic [WIN_W-1:0] rem;

  // words remaining up to and including ADDR_END; the last burst gets truncated to this
  always_comb begin
    rem = {1'b0, ADDR_END} - {1'b0, addr} + WIN_W'(1);
    len = (rem < BURST_W) ? rem[BCNT_W-1:0] : BURST_W[BCNT_W-1:0];
  end

endmodule

// File: rtl/ddram_clear.sv
// DDR3 fill engine: sweeps [ADDR_START..ADDR_END] with Avalon-MM write bursts of FILL.
module ddram_clear
  import ddram_clear_pkg::*;
#(
  parameter logic [DDR_AW-1:0] ADDR_START = 29'h0000000,
  parameter logic [DDR_AW-1:0] ADDR_END   = 29'h1FFFFFF,
  parameter int                BURST      = 64,
  parameter logic [DDR_DW-1:0] FILL       = 64'h0,
  parameter bit                LOOP       = 1'b1
)(
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              en,
  input  logic              DDRAM_BUSY,
  output logic [BCNT_W-1:0] DDRAM_BURSTCNT,
  output logic [DDR_AW-1:0] DDRAM_ADDR,
  output logic [DDR_DW-1:0] DDRAM_DIN,
  output logic [7:0]        DDRAM_BE,
  output logic              DDRAM_WE,
  output logic              DDRAM_RD,
  output logic              active,
  output logic              pass_done,
  output logic [7:0]        pass_cnt
);

  localparam logic [WIN_W-1:0]  WIN       = {1'b0, ADDR_END} - {1'b0, ADDR_START} + WIN_W'(1);
  localparam logic [WIN_W-1:0]  BURST_W   = WIN_W'(BURST);
  localparam logic [BCNT_W-1:0] INIT_BCNT = (WIN < BURST_W) ? WIN[BCNT_W-1:0] : BURST_W[BCNT_W-1:0];

  state_t            state, state_nx;
  logic [BCNT_W-1:0] beat;
  logic [BCNT_W-1:0] next_len;
  logic              beat_ok, last_beat, end_hit, load_len;

  ddram_burst_len #(
    .ADDR_END (ADDR_END),
    .BURST    (BURST)
  ) u_len (
    .addr (DDRAM_ADDR),
    .len  (next_len)
  );

  assign beat_ok   = (state == WRITE) && !DDRAM_BUSY;
  assign last_beat = beat_ok && (beat == DDRAM_BURSTCNT - BCNT_W'(1));
  // current burst covers ADDR_END as its final word
  assign end_hit   = ({1'b0, DDRAM_ADDR} + WIN_W'(DDRAM_BURSTCNT)) == ({1'b0, ADDR_END} + WIN_W'(1));

  // WE follows state so an async reset drops it in the same cycle
  assign DDRAM_WE  = (state == WRITE);
  assign DDRAM_RD  = 1'b0;
  assign DDRAM_DIN = FILL;
  assign DDRAM_BE  = 8'hFF;
  assign active    = (state == WRITE) || (state == GAP);

  // state register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state; en only matters at burst boundaries (IDLE, GAP, DONE)
  always_comb begin
    state_nx = state;
    load_len = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nx = WRITE;
          load_len = 1'b1;
        end
      end
      WRITE: begin
        if (last_beat) state_nx = GAP;
      end
      GAP: begin
        load_len = 1'b1;
        if (pass_done && !LOOP) state_nx = DONE;
        else if (en)            state_nx = WRITE;
        else                    state_nx = IDLE;
      end
      DONE: begin
        if (!en) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // burst datapath: beat count, address advance, pass bookkeeping
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      beat           <= '0;
      DDRAM_ADDR     <= ADDR_START;
      DDRAM_BURSTCNT <= INIT_BCNT;
      pass_done      <= 1'b0;
      pass_cnt       <= '0;
    end else begin
      pass_done <= 1'b0;
      if (beat_ok) beat <= last_beat ? '0 : beat + BCNT_W'(1);
      // address moves on once the burst is fully accepted, ready for the GAP reload
      if (last_beat) begin
        if (end_hit) begin
          DDRAM_ADDR <= ADDR_START;
          pass_done  <= 1'b1;
          pass_cnt   <= pass_cnt + 8'd1;
        end else begin
          DDRAM_ADDR <= DDRAM_ADDR + DDR_AW'(DDRAM_BURSTCNT);
        end
      end
      if (load_len) DDRAM_BURSTCNT <= next_len;
    end
  end

endmodule
